// File: rtl/sevenseg_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with inter-digit blanking
// and a staging register that updates the display only at frame boundaries.
module sevenseg_scan_ctrl #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned DIGIT_HZ     = 1000,
  parameter int unsigned BLANK_CYCLES = 200,
  parameter int unsigned N_DIGITS     = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] digit_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  input  logic        update,
  output logic        update_ack,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned DWELL = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CW    = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   act_data, stg_data;
  logic [7:0]    act_en, stg_en, act_dp, stg_dp;
  logic          pending;

  logic          slot_end, frame_end;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (cnt == CW'(DWELL - 1));
    frame_end = slot_end && (idx == 3'(N_DIGITS - 1));
    nibble    = act_data[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      act_data   <= '0;
      act_en     <= '0;
      act_dp     <= '0;
      stg_data   <= '0;
      stg_en     <= '0;
      stg_dp     <= '0;
      pending    <= 1'b0;
      update_ack <= 1'b0;
      frame_tick <= 1'b0;
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
    end else begin
      update_ack <= 1'b0;
      frame_tick <= 1'b0;

      if (slot_end) begin
        cnt   <= '0;
        state <= (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        idx   <= frame_end ? '0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
        if (32'(cnt) + 32'd1 == BLANK_CYCLES) state <= DRIVE;
      end

      // The copy reads staging before this cycle's capture, so an update
      // landing on the frame-end edge stays pending for the following frame.
      if (frame_end) begin
        frame_tick <= 1'b1;
        if (pending) begin
          act_data   <= stg_data;
          act_en     <= stg_en;
          act_dp     <= stg_dp;
          pending    <= 1'b0;
          update_ack <= 1'b1;
        end
      end

      if (update) begin
        stg_data <= digit_data;
        stg_en   <= digit_en;
        stg_dp   <= dp_in;
        pending  <= 1'b1;
      end

      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
      if (state == DRIVE && act_en[idx]) begin
        an[idx] <= 1'b0;
        seg     <= hex_to_seg(nibble);
        dp      <= ~act_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl: DWELL=10, BLANK=2, 8 digits, 80-cycle frame.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] digit_data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic        update;
  logic        update_ack;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  sevenseg_scan_ctrl #(
    .CLK_HZ(1000),
    .DIGIT_HZ(100),
    .BLANK_CYCLES(2),
    .N_DIGITS(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .digit_data(digit_data),
    .digit_en(digit_en),
    .dp_in(dp_in),
    .update(update),
    .update_ack(update_ack),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    update = 1'b0;
    repeat (3) step();
    check("rst_disp", 32'({an, seg, dp}), 32'h0000_FFFF);
    check("rst_ack",  32'(update_ack), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    resetn = 1'b1;
    cyc    = 0;
  endtask

  // One 80-cycle frame; data/en/dpv is the content expected on screen, p1/p2 are
  // in-frame positions at which an update is driven (-1 = none).
  task automatic run_frame(input string tag,
                           input logic [31:0] data, input logic [7:0] en, input logic [7:0] dpv,
                           input int p1, input logic [31:0] d1,
                           input int p2, input logic [31:0] d2,
                           input logic [7:0] uen, input logic [7:0] udp,
                           input logic exp_ack);
    logic [7:0]  an_e;
    logic [15:0] e;
    int d, c;
    for (int i = 0; i < 80; i++) begin
      if (i == p1) begin
        update = 1'b1; digit_data = d1; digit_en = uen; dp_in = udp;
      end else if (i == p2) begin
        update = 1'b1; digit_data = d2; digit_en = uen; dp_in = udp;
      end
      step();
      update = 1'b0;
      d = i / 10;
      c = i % 10;
      if (c < 2 || !en[d]) begin
        e = {8'hFF, 7'h7F, 1'b1};
      end else begin
        an_e    = 8'hFF;
        an_e[d] = 1'b0;
        e = {an_e, seg_tbl[data[4*d +: 4]], ~dpv[d]};
      end
      check({tag, "_disp"}, 32'({an, seg, dp}), 32'(e));
      check({tag, "_tick"}, 32'(frame_tick), 32'(i == 79));
      check({tag, "_ack"},  32'(update_ack), 32'(exp_ack && i == 79));
    end
  endtask

  initial begin
    digit_data = '0;
    digit_en   = '0;
    dp_in      = '0;
    update     = 1'b0;
    resetn     = 1'b0;

    // Dark after reset, ticks every 80 cycles.
    do_reset();
    repeat (3) run_frame("dark", 32'h0, 8'h00, 8'h00, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00, 1'b0);

    // Basic update 5 cycles after reset.
    do_reset();
    run_frame("basic_ld", 32'h0, 8'h00, 8'h00, 5, 32'h7654_3210, -1, 32'h0, 8'hFF, 8'h01, 1'b1);
    run_frame("basic",    32'h7654_3210, 8'hFF, 8'h01, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00, 1'b0);

    // Tear-free: mid-frame update does not touch the current frame.
    run_frame("tear_ld", 32'h7654_3210, 8'hFF, 8'h01, 30, 32'h8888_8888, -1, 32'h0, 8'hFF, 8'h00, 1'b1);
    run_frame("tear",    32'h8888_8888, 8'hFF, 8'h00, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00, 1'b0);

    // Last update wins, single ack.
    run_frame("last_ld", 32'h8888_8888, 8'hFF, 8'h00, 10, 32'h1111_1111, 50, 32'hFFFF_FFFF, 8'hFF, 8'h00, 1'b1);
    run_frame("last",    32'hFFFF_FFFF, 8'hFF, 8'h00, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00, 1'b0);

    // Update on the frame-end edge: acked one frame later; then disabled digit 2.
    run_frame("coll_ld",  32'hFFFF_FFFF, 8'hFF, 8'h00, 79, 32'h9ABC_D0EF, -1, 32'h0, 8'hFB, 8'hFF, 1'b0);
    run_frame("coll_ack", 32'hFFFF_FFFF, 8'hFF, 8'h00, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00, 1'b1);
    run_frame("dis",      32'h9ABC_D0EF, 8'hFB, 8'hFF, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00, 1'b0);

    // Reset at frame cycle 45 with an update pending.
    for (int i = 0; i < 45; i++) begin
      if (i == 10) begin
        update = 1'b1; digit_data = 32'h8888_8888; digit_en = 8'hFF; dp_in = 8'h00;
      end
      step();
      update = 1'b0;
    end
    check("mid_pre", 32'({an, seg, dp}), 32'({8'hEF, 7'h46, 1'b0}));
    resetn = 1'b0;
    step();
    check("mid_disp", 32'({an, seg, dp}), 32'h0000_FFFF);
    check("mid_ack",  32'(update_ack), 32'd0);
    check("mid_tick", 32'(frame_tick), 32'd0);
    repeat (2) step();
    resetn = 1'b1;
    cyc    = 0;
    repeat (2) run_frame("post_rst", 32'h0, 8'h00, 8'h00, -1, 32'h0, -1, 32'h0, 8'h00, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
